hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15 (4-bit range 1..15): maximum consecutive data-memory wait cycles tolerated before timeout.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 id_rs, id_rt  in  3 each  source register fields of instruction in decode.
REQ-005 id_rs_v, id_rt_v  in  1 each  decode source field is a real source.
REQ-006 ex_rs, ex_rt  in  3 each; ex_rs_v, ex_rt_v  in  1 each  same, for instruction in execute.
REQ-007 ex_rd  in  3; ex_regwrt  in  1; ex_memread  in  1  execute-stage destination, write enable, load flag.
REQ-008 mem_rd  in  3; mem_regwrt  in  1; mem_memread  in  1  memory-stage destination, write enable, load flag.
REQ-009 wb_rd  in  3; wb_regwrt  in  1  writeback-stage destination and write enable.
REQ-010 pcsrc  in  1  branch/jump taken, resolved in execute.
REQ-011 dmem_stall  in  1  data memory busy; pipeline must freeze.
REQ-012 forward_A, forward_B  out  2 each  execute operand select: 00 register file, 01 writeback data, 10 memory-stage ALU result.
REQ-013 stall_pc, stall_ifid  out  1 each  hold PC / hold IF-ID register.
REQ-014 bubble_idex  out  1  load NOP into ID-EX register.
REQ-015 flush_ifid  out  1  load NOP into IF-ID register.
REQ-016 freeze_all  out  1  hold ID-EX, EX-MEM, MEM-WB registers.
REQ-017 timeout_err  out  1  sticky memory-wait timeout flag.
REQ-018 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-019 FSM states RUN, MEM_WAIT, TIMEOUT; 4-bit wait_cnt; state, wait_cnt, timeout_err, counters are registered; all other outputs are combinational from state and inputs.
REQ-020 Forwarding, operand A: 10 if ex_rs_v & mem_regwrt & ~mem_memread & mem_rd==ex_rs; else 01 if ex_rs_v & wb_regwrt & wb_rd==ex_rs; else 00; R0 is an ordinary register (no zero-register exclusion).
REQ-021 Operand B identical using ex_rt/ex_rt_v; memory stage has priority over writeback.
REQ-022 Load-use hazard = ex_memread & ex_regwrt & ((id_rs_v & id_rs==ex_rd) | (id_rt_v & id_rt==ex_rd)).
REQ-023 Priority per cycle: rst > dmem_stall > pcsrc > load-use.
REQ-024 dmem_stall=1 (RUN or MEM_WAIT): freeze_all=stall_pc=stall_ifid=1, flush_ifid=bubble_idex=0.
REQ-025 pcsrc=1, dmem_stall=0, state not TIMEOUT: flush_ifid=1, bubble_idex=1, stall_pc=0, stall_ifid=0 (same cycle, no added latency).
REQ-026 Load-use, no dmem_stall, no pcsrc: stall_pc=1, stall_ifid=1, bubble_idex=1 for exactly that cycle; freeze_all=0.
REQ-027 RUN with dmem_stall=1: next state MEM_WAIT, wait_cnt<=1.
REQ-028 MEM_WAIT with dmem_stall=1: if wait_cnt==MAX_WAIT, next TIMEOUT and timeout_err<=1; else wait_cnt<=wait_cnt+1.
REQ-029 MEM_WAIT with dmem_stall=0: next RUN, wait_cnt<=0; that cycle's outputs follow REQ-025/026 as in RUN.
REQ-030 Timeout fires after MAX_WAIT+1 consecutive dmem_stall cycles; timeout_err visible the following cycle.
REQ-031 TIMEOUT: freeze_all=stall_pc=stall_ifid=1, flush/bubble=0, forwards 00, regardless of inputs; exits only by rst.
REQ-032 stall_cnt +1 each non-reset cycle with stall_pc=1; flush_cnt +1 each non-reset cycle with flush_ifid=1; both hold at 16'hFFFF.

Reset
REQ-033 rst sampled high: state<=RUN, wait_cnt<=0, timeout_err<=0, stall_cnt<=0, flush_cnt<=0.
REQ-034 While rst=1 all combinational outputs are 0 (forwards 00), including mid-MEM_WAIT and in TIMEOUT.

Verification
REQ-035 ex_rs=3,ex_rs_v=1, mem_rd=3,mem_regwrt=1, wb_rd=3,wb_regwrt=1 -> forward_A=10; drop mem_regwrt -> 01; set mem_memread=1 with mem_regwrt=1 -> 01.
REQ-036 ex_memread=1,ex_regwrt=1,ex_rd=5, id_rt=5,id_rt_v=1 -> one cycle stall_pc=stall_ifid=bubble_idex=1, stall_cnt 0->1; same with pcsrc=1 -> flush_ifid=bubble_idex=1, stall_pc=0, flush_cnt 0->1.
REQ-037 dmem_stall=1 for 3 cycles with pcsrc=1 -> freeze_all=1 and flush_ifid=0 for 3 cycles, then flush_ifid=1 on release cycle; state returns RUN, timeout_err=0.
REQ-038 MAX_WAIT=15, dmem_stall held 16 cycles -> timeout_err=1 on cycle 17 and stays 1 after dmem_stall drops; rst -> timeout_err=0, state RUN.
REQ-039 Preload stall_cnt to 16'hFFFE via sustained stalls, continue stalling -> saturates at 16'hFFFF; rst asserted mid-MEM_WAIT -> all outputs 0 that cycle, counters 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline forwarding, load-use/branch hazard control and data-memory wait supervision.
module hazard_ctrl #(
    parameter logic [3:0] MAX_WAIT = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_v,
    input  logic        id_rt_v,
    input  logic [2:0]  ex_rs,
    input  logic [2:0]  ex_rt,
    input  logic        ex_rs_v,
    input  logic        ex_rt_v,
    input  logic [2:0]  ex_rd,
    input  logic        ex_regwrt,
    input  logic        ex_memread,
    input  logic [2:0]  mem_rd,
    input  logic        mem_regwrt,
    input  logic        mem_memread,
    input  logic [2:0]  wb_rd,
    input  logic        wb_regwrt,
    input  logic        pcsrc,
    input  logic        dmem_stall,
    output logic [1:0]  forward_A,
    output logic [1:0]  forward_B,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        freeze_all,
    output logic        timeout_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] TIMEOUT  = 2'd2;

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic       load_use;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign load_use = ex_memread & ex_regwrt &
                      ((id_rs_v & (id_rs == ex_rd)) | (id_rt_v & (id_rt == ex_rd)));
    // A load in memory stage has no ALU result worth forwarding, so it falls through to writeback.
    assign fwd_a = (ex_rs_v & mem_regwrt & ~mem_memread & (mem_rd == ex_rs)) ? 2'b10 :
                   (ex_rs_v & wb_regwrt & (wb_rd == ex_rs)) ? 2'b01 : 2'b00;
    assign fwd_b = (ex_rt_v & mem_regwrt & ~mem_memread & (mem_rd == ex_rt)) ? 2'b10 :
                   (ex_rt_v & wb_regwrt & (wb_rd == ex_rt)) ? 2'b01 : 2'b00;

    always_comb begin
        forward_A   = 2'b00;
        forward_B   = 2'b00;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze_all  = 1'b0;
        if (!rst) begin
            if (state == TIMEOUT) begin
                {freeze_all, stall_pc, stall_ifid} = 3'b111;
            end else begin
                forward_A = fwd_a;
                forward_B = fwd_b;
                if (dmem_stall)
                    {freeze_all, stall_pc, stall_ifid} = 3'b111;
                else if (pcsrc)
                    {flush_ifid, bubble_idex} = 2'b11;
                else if (load_use)
                    {stall_pc, stall_ifid, bubble_idex} = 3'b111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 4'd0;
            timeout_err <= 1'b0;
            stall_cnt   <= 16'd0;
            flush_cnt   <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_stall) begin
                        state    <= RUN;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == MAX_WAIT) begin
                        state       <= TIMEOUT;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                TIMEOUT: ;
                default: state <= RUN;
            endcase
            if (stall_pc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_ifid && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl; expected control vectors are queued per driven cycle.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_rs_v, id_rt_v, ex_rs_v, ex_rt_v;
    logic        ex_regwrt, ex_memread, mem_regwrt, mem_memread, wb_regwrt;
    logic        pcsrc, dmem_stall;
    logic [1:0]  forward_A, forward_B;
    logic        stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all, timeout_err;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;
    sb_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    // Expected vector layout: {forward_A, forward_B, stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all}
    localparam logic [8:0] E_IDLE  = 9'b00_00_00000;
    localparam logic [8:0] E_LOAD  = 9'b00_00_11100;
    localparam logic [8:0] E_FLUSH = 9'b00_00_00110;
    localparam logic [8:0] E_FRZ   = 9'b00_00_11001;

    hazard_ctrl #(.MAX_WAIT(4'd15)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_v(id_rs_v), .id_rt_v(id_rt_v),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_v(ex_rs_v), .ex_rt_v(ex_rt_v),
        .ex_rd(ex_rd), .ex_regwrt(ex_regwrt), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrt(mem_regwrt), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrt(wb_regwrt),
        .pcsrc(pcsrc), .dmem_stall(dmem_stall),
        .forward_A(forward_A), .forward_B(forward_B),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .freeze_all(freeze_all), .timeout_err(timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs_v, id_rt_v, ex_rs_v, ex_rt_v} = '0;
        {ex_regwrt, ex_memread, mem_regwrt, mem_memread, wb_regwrt} = '0;
        {pcsrc, dmem_stall} = '0;
    endtask

    // Inputs are already applied; queue the expectation, compare mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        sb_t e;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, {23'd0, forward_A, forward_B, stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all},
            {23'd0, e.exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b1;
        dmem_stall = 1'b1;
        pcsrc = 1'b1;
        ex_rs = 3'd3; ex_rs_v = 1'b1; mem_rd = 3'd3; mem_regwrt = 1'b1;
        cyc("rst_outs0", E_IDLE);
        cyc("rst_outs1", E_IDLE);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);

        clr(); rst = 1'b0;
        ex_rs = 3'd3; ex_rs_v = 1'b1; mem_rd = 3'd3; mem_regwrt = 1'b1; wb_rd = 3'd3; wb_regwrt = 1'b1;
        cyc("fwdA_mem", 9'b10_00_00000);
        mem_regwrt = 1'b0;
        cyc("fwdA_wb", 9'b01_00_00000);
        mem_regwrt = 1'b1; mem_memread = 1'b1;
        cyc("fwdA_load_skip", 9'b01_00_00000);
        ex_rs_v = 1'b0;
        cyc("fwdA_invalid", E_IDLE);
        clr(); ex_rt = 3'd6; ex_rt_v = 1'b1; mem_rd = 3'd6; mem_regwrt = 1'b1; wb_rd = 3'd6; wb_regwrt = 1'b1;
        cyc("fwdB_mem_prio", 9'b00_10_00000);
        clr(); ex_rt = 3'd0; ex_rt_v = 1'b1; ex_rs = 3'd0; ex_rs_v = 1'b1; wb_rd = 3'd0; wb_regwrt = 1'b1;
        cyc("fwd_r0_wb", 9'b01_01_00000);

        clr(); ex_memread = 1'b1; ex_regwrt = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_rt_v = 1'b1;
        cyc("loaduse_rt", E_LOAD);
        chk("loaduse_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        id_rt_v = 1'b0;
        cyc("loaduse_rt_invalid", E_IDLE);
        id_rs = 3'd5; id_rs_v = 1'b1; ex_regwrt = 1'b0;
        cyc("loaduse_no_regwrt", E_IDLE);
        ex_regwrt = 1'b1;
        cyc("loaduse_rs", E_LOAD);
        chk("loaduse_stall_cnt2", {16'd0, stall_cnt}, 32'd2);
        pcsrc = 1'b1;
        cyc("branch_over_loaduse", E_FLUSH);
        chk("branch_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("branch_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        clr(); pcsrc = 1'b1; dmem_stall = 1'b1;
        cyc("dmem_frz1", E_FRZ);
        cyc("dmem_frz2", E_FRZ);
        cyc("dmem_frz3", E_FRZ);
        dmem_stall = 1'b0;
        cyc("dmem_release_flush", E_FLUSH);
        chk("dmem_stall_cnt", {16'd0, stall_cnt}, 32'd5);
        chk("dmem_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        pcsrc = 1'b0;
        cyc("dmem_back_run", E_IDLE);
        chk("dmem_no_timeout", {31'd0, timeout_err}, 32'd0);

        dmem_stall = 1'b1;
        for (int i = 0; i < 15; i++) cyc("to_wait", E_FRZ);
        chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
        cyc("to_wait16", E_FRZ);
        chk("to_fired", {31'd0, timeout_err}, 32'd1);
        clr(); pcsrc = 1'b1;
        ex_rs = 3'd2; ex_rs_v = 1'b1; mem_rd = 3'd2; mem_regwrt = 1'b1;
        ex_memread = 1'b1; ex_regwrt = 1'b1; ex_rd = 3'd1; id_rs = 3'd1; id_rs_v = 1'b1;
        cyc("to_hold_a", E_FRZ);
        pcsrc = 1'b0;
        cyc("to_hold_b", E_FRZ);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
        chk("to_stall_cnt", {16'd0, stall_cnt}, 32'd23);
        rst = 1'b1;
        cyc("to_rst_outs", E_IDLE);
        chk("to_rst_err", {31'd0, timeout_err}, 32'd0);
        chk("to_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        clr(); rst = 1'b0; pcsrc = 1'b1;
        cyc("to_rst_run", E_FLUSH);

        clr(); ex_memread = 1'b1; ex_regwrt = 1'b1; ex_rd = 3'd4; id_rs = 3'd4; id_rs_v = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_preload", {16'd0, stall_cnt}, 32'h0000FFFE);
        cyc("sat_a", E_LOAD);
        chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        cyc("sat_b", E_LOAD);
        chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
        clr(); dmem_stall = 1'b1;
        cyc("sat_mw1", E_FRZ);
        cyc("sat_mw2", E_FRZ);
        rst = 1'b1; pcsrc = 1'b1;
        cyc("mw_rst_outs", E_IDLE);
        chk("mw_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mw_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        clr(); rst = 1'b0;
        cyc("mw_rst_idle", E_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
